// File: rtl/uart_transceiver_if.sv
// CPU-side bus of the UART: TX valid/ready handshake plus the RX FIFO head,
// pop handshake and overrun status.
interface uart_transceiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overrun;
    logic                 rx_overrun_clr;

    modport master (
        output tx_data, tx_valid, rx_ready, rx_overrun_clr,
        input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, rx_overrun_clr,
        output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART: shared oversampling tick, TX FSM with valid/ready intake,
// RX FSM with mid-bit sampling and a status-carrying RX FIFO.
module uart_transceiver #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int RX_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_transceiver_if.slave   bus,
    output logic                txd,
    input  logic                rxd
);
    localparam int DIV_CALC = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int AW       = $clog2(RX_DEPTH);
    localparam int EW       = DATA_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- oversampling tick ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             os_tick;

    assign os_tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (os_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    state_t               tx_state;
    logic [OS_W-1:0]      tx_tick;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 txd_q;
    logic                 tx_ready_q;
    logic                 tx_bit_done;

    assign tx_bit_done = os_tick && (tx_tick == OS_LAST);
    assign txd         = txd_q;
    assign bus.tx_ready = tx_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state   <= S_IDLE;
            tx_tick    <= '0;
            tx_bit     <= '0;
            tx_stop    <= 1'b0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            if (tx_state != S_IDLE && os_tick) tx_tick <= tx_tick + 1'b1;
            case (tx_state)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        tx_shift   <= bus.tx_data;
                        tx_par     <= (^bus.tx_data) ^ PAR_ODD;
                        tx_tick    <= '0;
                        tx_bit     <= '0;
                        tx_stop    <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_state   <= S_START;
                    end
                end
                S_START: begin
                    if (tx_bit_done) begin
                        txd_q    <= tx_shift[0];
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_bit_done) begin
                        if (tx_bit == BIT_LAST) begin
                            if (PARITY != 0) begin
                                txd_q    <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                txd_q    <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            txd_q    <= tx_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_bit_done) begin
                        txd_q    <= 1'b1;
                        tx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tx_bit_done) begin
                        if (tx_stop == STOP_LAST) begin
                            tx_ready_q <= 1'b1;
                            tx_state   <= S_IDLE;
                        end else begin
                            tx_stop <= 1'b1;
                        end
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_meta;
    logic                 rxs;
    state_t               rx_state;
    logic [OS_W-1:0]      rx_tick;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr_q;
    logic                 rx_sample;
    logic                 push;
    logic [EW-1:0]        push_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign rx_sample = os_tick && (rx_tick == OS_LAST);
    assign push      = (rx_state == S_STOP) && rx_sample;
    assign push_word = {rx_perr_q, ~rxs, rx_shift};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state  <= S_IDLE;
            rx_tick   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_perr_q <= 1'b0;
        end else begin
            if (rx_state != S_IDLE && os_tick) rx_tick <= rx_tick + 1'b1;
            case (rx_state)
                S_IDLE: begin
                    if (!rxs) begin
                        rx_tick  <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    // Half-bit recheck rejects glitches shorter than half a bit.
                    if (os_tick && rx_tick == OS_HALF) begin
                        if (rxs) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_tick   <= '0;
                            rx_bit    <= '0;
                            rx_perr_q <= 1'b0;
                            rx_state  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_sample) begin
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_LAST) begin
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (rx_sample) begin
                        rx_perr_q <= rxs ^ (^rx_shift) ^ PAR_ODD;
                        rx_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_sample) rx_state <= S_IDLE;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] mem [RX_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          overrun_q;
    logic [EW-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.rx_ready;
    assign push_ok = push && (!full || pop);

    // NOTE: the storage array has no reset; entries are only visible through
    // rx_valid, so clearing them would add reset fan-out for no behaviour.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) begin
                overrun_q <= 1'b1;
            end else if (bus.rx_overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head           = mem[rd_ptr[AW-1:0]];
    assign bus.rx_valid   = !empty;
    assign bus.rx_data    = empty ? '0 : head[DATA_BITS-1:0];
    assign bus.rx_ferr    = empty ? 1'b0 : head[DATA_BITS];
    assign bus.rx_perr    = empty ? 1'b0 : head[DATA_BITS+1];
    assign bus.rx_overrun = overrun_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench: dut_a is 8N1 (depth 4), dut_b is 7 data bits, even parity,
// two stop bits. One bit period is 16 clk (DIV = 1).
module tb_uart_transceiver;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic txd_a, txd_b;
    logic rxd_a, rxd_b;
    logic rxd_a_drv, rxd_b_drv;
    logic loop_a, loop_b;

    assign rxd_a = loop_a ? txd_a : rxd_a_drv;
    assign rxd_b = loop_b ? txd_b : rxd_b_drv;

    uart_transceiver_if #(.DATA_BITS(8)) bus_a ();
    uart_transceiver_if #(.DATA_BITS(7)) bus_b ();

    uart_transceiver #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .txd(txd_a), .rxd(rxd_a)
    );

    uart_transceiver #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .RX_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .txd(txd_b), .rxd(rxd_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_txd(input bit sel);
        return sel ? txd_b : txd_a;
    endfunction
    function automatic logic get_tx_ready(input bit sel);
        return sel ? bus_b.tx_ready : bus_a.tx_ready;
    endfunction
    function automatic logic get_rx_valid(input bit sel);
        return sel ? bus_b.rx_valid : bus_a.rx_valid;
    endfunction
    function automatic logic [7:0] get_rx_data(input bit sel);
        return sel ? {1'b0, bus_b.rx_data} : bus_a.rx_data;
    endfunction
    function automatic logic get_perr(input bit sel);
        return sel ? bus_b.rx_perr : bus_a.rx_perr;
    endfunction
    function automatic logic get_ferr(input bit sel);
        return sel ? bus_b.rx_ferr : bus_a.rx_ferr;
    endfunction
    function automatic logic get_overrun(input bit sel);
        return sel ? bus_b.rx_overrun : bus_a.rx_overrun;
    endfunction

    task automatic set_rx_ready(input bit sel, input logic v);
        if (sel) bus_b.rx_ready = v;
        else     bus_a.rx_ready = v;
    endtask
    task automatic set_rxd(input bit sel, input logic v);
        if (sel) rxd_b_drv = v;
        else     rxd_a_drv = v;
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic start_tx(input bit sel, input logic [7:0] d);
        if (sel) begin
            bus_b.tx_data  = d[6:0];
            bus_b.tx_valid = 1'b1;
        end else begin
            bus_a.tx_data  = d;
            bus_a.tx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_a.tx_valid = 1'b0;
        bus_b.tx_valid = 1'b0;
    endtask

    // Sends one byte and checks every bit mid-period plus the busy duration.
    task automatic send_tx(input bit sel, input logic [7:0] d, input int nbits,
                           input logic [15:0] frame, input int exp_low, input string name);
        int low;
        @(negedge clk);
        check({name, "_ready_idle"}, get_tx_ready(sel), 1);
        check({name, "_txd_idle"}, get_txd(sel), 1);
        start_tx(sel, d);
        low = 0;
        for (int n = 1; n <= nbits * 16 + 16; n++) begin
            @(negedge clk);
            if (!get_tx_ready(sel)) low++;
            if (n == 1) check({name, "_first_low"}, get_txd(sel), 0);
            if (n % 16 == 8 && n / 16 < nbits)
                check($sformatf("%s_bit%0d", name, n / 16), get_txd(sel), frame[n / 16]);
        end
        check({name, "_ready_low_clks"}, low, exp_low);
    endtask

    // Drives a frame LSB first, 16 clk per bit; must be called at a negedge.
    task automatic drive_rx(input bit sel, input logic [15:0] frame, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            set_rxd(sel, frame[b]);
            repeat (16) @(negedge clk);
        end
        set_rxd(sel, 1'b1);
    endtask

    task automatic pop_check(input bit sel, input logic [7:0] exp_d, input logic exp_p,
                             input logic exp_f, input string name);
        int n;
        n = 0;
        while (!get_rx_valid(sel) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, get_rx_valid(sel), 1);
        check({name, "_data"}, get_rx_data(sel), exp_d);
        check({name, "_perr"}, get_perr(sel), exp_p);
        check({name, "_ferr"}, get_ferr(sel), exp_f);
        set_rx_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rx_ready(sel, 1'b0);
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    typedef struct {
        bit         sel;
        logic [7:0] tx;
        int         nbits;
        logic [15:0] frame;
        int         ready_low;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[6];
    logic [15:0] bad_par;

    initial begin
        // Expected line frames, LSB = start bit, written out by hand.
        vecs[0] = '{1'b0, 8'hA5, 10, 16'b000000_1_10100101_0, 160, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 10, 16'b000000_1_00000000_0, 160, 8'h00};
        vecs[2] = '{1'b0, 8'hFF, 10, 16'b000000_1_11111111_0, 160, 8'hFF};
        vecs[3] = '{1'b0, 8'h81, 10, 16'b000000_1_10000001_0, 160, 8'h81};
        vecs[4] = '{1'b1, 8'h41, 11, 16'b00000_11_0_1000001_0, 176, 8'h41};
        vecs[5] = '{1'b1, 8'h7F, 11, 16'b00000_11_1_1111111_0, 176, 8'h7F};

        rst_n = 1'b0;
        loop_a = 1'b1;
        loop_b = 1'b1;
        rxd_a_drv = 1'b1;
        rxd_b_drv = 1'b1;
        bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0; bus_a.rx_overrun_clr = 1'b0;
        bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0; bus_b.rx_overrun_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 1);
        check("rst_tx_ready", bus_a.tx_ready, 1);
        check("rst_rx_valid", bus_a.rx_valid, 0);
        check("rst_rx_overrun", bus_a.rx_overrun, 0);
        check("rst_rx_data", bus_a.rx_data, 0);
        check("rst_b_txd", txd_b, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback table: TX waveform, busy time and received byte.
        for (int i = 0; i < 6; i++) begin
            send_tx(vecs[i].sel, vecs[i].tx, vecs[i].nbits, vecs[i].frame,
                    vecs[i].ready_low, $sformatf("vec%0d", i));
            pop_check(vecs[i].sel, vecs[i].rx, 1'b0, 1'b0, $sformatf("vec%0d_rx", i));
        end

        // 7E2 frame for 0x41 with the parity bit flipped.
        loop_b = 1'b0;
        bad_par = {5'b0, 2'b11, 1'b1, 7'h41, 1'b0};
        @(negedge clk);
        drive_rx(1'b1, bad_par, 11);
        pop_check(1'b1, 8'h41, 1'b1, 1'b0, "parity_err");

        // Framing error, then a short glitch that must not start a frame.
        loop_a = 1'b0;
        @(negedge clk);
        drive_rx(1'b0, frame8(8'h3C, 1'b0), 10);
        pop_check(1'b0, 8'h3C, 1'b0, 1'b1, "frame_err");
        repeat (40) @(negedge clk);
        check("glitch_pre_empty", bus_a.rx_valid, 0);
        set_rxd(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        set_rxd(1'b0, 1'b1);
        repeat (40) @(negedge clk);
        check("glitch_no_push", bus_a.rx_valid, 0);

        // Overrun: five frames into a four-entry FIFO with no consumer.
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) check("ovr_clear_when_full", bus_a.rx_overrun, 0);
            drive_rx(1'b0, frame8(8'(i), 1'b1), 10);
        end
        repeat (2) @(negedge clk);
        check("ovr_set", bus_a.rx_overrun, 1);
        for (int i = 1; i <= 4; i++) pop_check(1'b0, 8'(i), 1'b0, 1'b0, $sformatf("ovr_pop%0d", i));
        check("ovr_drained", bus_a.rx_valid, 0);
        check("ovr_sticky", bus_a.rx_overrun, 1);
        @(negedge clk);
        bus_a.rx_overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        bus_a.rx_overrun_clr = 1'b0;
        check("ovr_cleared", bus_a.rx_overrun, 0);

        // Full FIFO, pop coincides with the fifth push edge.
        @(negedge clk);
        for (int i = 1; i <= 4; i++) drive_rx(1'b0, frame8(8'h10 + 8'(i), 1'b1), 10);
        fork
            drive_rx(1'b0, frame8(8'h15, 1'b1), 10);
            begin
                repeat (154) @(posedge clk);
                #1 set_rx_ready(1'b0, 1'b1);
                @(posedge clk);
                #1 set_rx_ready(1'b0, 1'b0);
            end
        join
        repeat (2) @(negedge clk);
        check("pp_no_overrun", bus_a.rx_overrun, 0);
        for (int i = 2; i <= 5; i++) pop_check(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, $sformatf("pp_pop%0d", i));
        check("pp_drained", bus_a.rx_valid, 0);

        // Reset mid-TX and mid-RX with a full, overrun FIFO.
        @(negedge clk);
        for (int i = 1; i <= 5; i++) drive_rx(1'b0, frame8(8'h20 + 8'(i), 1'b1), 10);
        repeat (2) @(negedge clk);
        check("pre_rst_overrun", bus_a.rx_overrun, 1);
        loop_a = 1'b1;
        @(negedge clk);
        start_tx(1'b0, 8'hC3);
        repeat (60) @(negedge clk);
        check("pre_rst_txd", txd_a, 0);
        check("pre_rst_busy", bus_a.tx_ready, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_txd", txd_a, 1);
        check("mid_rst_tx_ready", bus_a.tx_ready, 1);
        check("mid_rst_rx_valid", bus_a.rx_valid, 0);
        check("mid_rst_overrun", bus_a.rx_overrun, 0);
        check("mid_rst_rx_data", bus_a.rx_data, 0);
        send_tx(1'b0, 8'h5A, 10, 16'b000000_1_01011010_0, 160, "post_rst");
        pop_check(1'b0, 8'h5A, 1'b0, 1'b0, "post_rst_rx");
        check("post_rst_empty", bus_a.rx_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex UART for the CPU's serial port; next generation of the fixed 8N2/8N1 transmitter/receiver pair.
- Adds run-time-free parametrisation: data width 5–8, none/odd/even parity, 1 or 2 stop bits.
- Uses an integer oversampling divider and a valid/ready TX handshake.
- The RX side has a parametrised FIFO with parity, framing and overrun status, so the CPU bus can poll without losing bytes.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, RX ticks per bit; power of 2, ≥8.
- DATA_BITS, 8, payload bits per frame, 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits sent (1 or 2); RX checks only the first.
- RX_DEPTH, 4, RX FIFO entries, power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter can accept a byte.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  head-of-FIFO data.
- rx_perr  out  1  head entry had a parity error.
- rx_ferr  out  1  head entry had a framing error (stop bit sampled 0).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops head when rx_valid & rx_ready.
- rx_overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- rx_overrun_clr  in  1  clears rx_overrun.

Behaviour:
Tick generator
- DIV = max(1, round(CLK_FREQ / (BAUD*OVERSAMPLE))).
- Free-running counter 0..DIV-1; os_tick pulses one clk when the counter wraps.
- TX bit period is OVERSAMPLE os_ticks, counted by a separate TX tick counter.

Reset (rst_n low at a clk edge), regardless of state, including mid-frame:
- txd=1, tx_ready=1.
- Both FSMs to IDLE; FIFO empty, so rx_valid=0, rx_data/rx_perr/rx_ferr=0.
- rx_overrun=0; synchroniser flops=1; counters=0.

TX FSM: IDLE→START→DATA→PARITY(if PARITY≠0)→STOP→IDLE.
- Accept on the clk edge where tx_valid & tx_ready. That edge latches tx_data, drops tx_ready, enters START, and restarts the TX tick counter.
- txd=0 for START.
- DATA shifts LSB first, DATA_BITS bit periods.
- PARITY bit = XOR of data (even) or its inverse (odd).
- txd=1 for STOP_BITS periods.
- tx_ready returns to 1 on the cycle the FSM re-enters IDLE, so back-to-back bytes have no extra idle gap.
- First txd low occurs the cycle after acceptance.
- tx_valid while busy is ignored and must be held by the producer.

RX path
- rxd passes through 2 flops (sampled every clk) to give rxs.
- RX FSM: IDLE→START→DATA→PARITY(opt)→STOP→IDLE; a sub-counter runs 0..OVERSAMPLE-1 on os_tick.
- IDLE: on rxs==0, go to START and reset the sub-counter.
- START: at count OVERSAMPLE/2-1, if rxs==1 it is a false start → IDLE with no push; otherwise reset the sub-counter and continue.
- Each later bit is sampled when the sub-counter reaches OVERSAMPLE-1, i.e. mid-bit.
- Data is assembled LSB first.
- parity_err = received parity ≠ expected; it is 0 when PARITY=0.
- ferr = stop sample == 0.
- On the stop sample, push {perr, ferr, data} and return to IDLE immediately, which enables the next start search within half a bit.
- Frames with errors are still pushed.

RX FIFO
- Circular buffer with log2(RX_DEPTH)+1-bit pointers.
- Push while full: the frame is dropped and rx_overrun is set to 1 next cycle.
- Push and pop in the same cycle while full: the pop frees space and the push succeeds, so no overrun.
- Pop while empty: ignored.
- rx_overrun_clr coinciding with a new overrun: set wins.
- rx_data/rx_perr/rx_ferr are combinational from the head entry and are only valid when rx_valid=1.
- Push to an empty FIFO: rx_valid=1 the following cycle.

Test Plan:
Bench parameters: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16, so DIV=1 and a bit period is 16 clk.
1. Default 8N1: send 0xA5 → txd low for 16 clk, then 1,0,1,0,0,1,0,1 each 16 clk, then high for 16 clk; tx_ready low for exactly 160 clk. Loop txd→rxd gives rx_data=0xA5, perr=0, ferr=0.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2: send 0x41 → parity bit 0, frame length 11 bits (176 clk). Inject the same frame on rxd with the parity bit flipped → rx_perr=1, rx_data=0x41.
3. Drive rxd frame 0x3C with the stop bit 0 → rx_ferr=1, rx_data=0x3C. Drive an 8-clk low glitch → false start, no push, rx_valid stays 0.
4. RX_DEPTH=4, rx_ready=0: receive 5 frames 0x01..0x05 → rx_overrun=1, FIFO pops 0x01..0x04 in order. Pulse rx_overrun_clr → rx_overrun=0.
5. Full FIFO with rx_ready=1 asserted on the cycle frame 5 pushes → no overrun; 0x05 becomes the last entry.
6. Drop rst_n for 1 clk mid-TX and mid-RX → next cycle txd=1, tx_ready=1, rx_valid=0, rx_overrun=0. The next byte 0x5A transmits and receives correctly.
